mx_dot_accumulator: RTL and testbench

//  Downstream of the block-scaled FP/INT dot-product tree. Consumes one (value, scale) partial dot

---
 rtl/mx_dot_accumulator.sv | 126 ++++++++++++
 tb/tb_mx_dot_accumulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mx_dot_accumulator.sv
// rtl/mx_dot_accumulator.sv - block-scaled partial dot-product accumulator with scale alignment and saturation
// Groups N_ACC (value, exponent) partials into one saturated (mantissa, exponent) result.
module mx_dot_accumulator #(
  parameter int IN_W    = 18,
  parameter int SCALE_W = 8,
  parameter int ACC_W   = 32,
  parameter int N_ACC   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [IN_W-1:0]    i_dp,
  input  logic signed [SCALE_W-1:0] i_scale,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [ACC_W-1:0]   o_acc,
  output logic signed [SCALE_W-1:0] o_scale,
  output logic                      o_ovf
);

  localparam int CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int SH_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;

  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [SCALE_W-1:0] acc_s;
  logic                      ovf_g;

  logic                      accept;
  logic                      first;
  logic                      last;
  logic signed [ACC_W-1:0]   ext_dp;
  logic signed [SCALE_W:0]   d;
  logic [SCALE_W:0]          mag;
  logic [SH_W-1:0]           sh;
  logic signed [ACC_W-1:0]   a_term;
  logic signed [ACC_W-1:0]   b_term;
  logic signed [ACC_W:0]     sum;
  logic                      sat;
  logic signed [ACC_W-1:0]   sat_sum;
  logic signed [ACC_W-1:0]   new_acc;
  logic signed [SCALE_W-1:0] new_s;
  logic                      new_ovf;

  assign o_ready = !(o_valid && !i_ready);
  assign accept  = i_valid && o_ready;
  assign first   = (cnt == '0);
  assign last    = (cnt == CNT_W'(N_ACC - 1));
  assign ext_dp  = ACC_W'(i_dp);

  // Align the operand with the smaller exponent to the larger one; shift is clamped to ACC_W-1.
  always_comb begin
    d   = $signed({i_scale[SCALE_W-1], i_scale}) - $signed({acc_s[SCALE_W-1], acc_s});
    mag = d[SCALE_W] ? $unsigned(-d) : $unsigned(d);
    if ({{(32-SCALE_W-1){1'b0}}, mag} > 32'(ACC_W - 1))
      sh = SH_W'(ACC_W - 1);
    else
      sh = mag[SH_W-1:0];
    if (!d[SCALE_W] && (d != '0)) begin
      a_term = acc >>> sh;
      b_term = ext_dp;
    end else begin
      a_term = acc;
      b_term = ext_dp >>> sh;
    end
  end

  always_comb begin
    sum = $signed({a_term[ACC_W-1], a_term}) + $signed({b_term[ACC_W-1], b_term});
    sat = (sum[ACC_W] != sum[ACC_W-1]);
    if (!sat)
      sat_sum = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      sat_sum = {1'b1, {(ACC_W-1){1'b0}}};
    else
      sat_sum = {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_comb begin
    if (first) begin
      new_acc = ext_dp;
      new_s   = i_scale;
      new_ovf = 1'b0;
    end else begin
      new_acc = sat_sum;
      new_s   = (!d[SCALE_W] && (d != '0)) ? i_scale : acc_s;
      new_ovf = ovf_g | sat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      acc     <= '0;
      acc_s   <= '0;
      ovf_g   <= 1'b0;
      o_valid <= 1'b0;
      o_acc   <= '0;
      o_scale <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (o_valid && i_ready)
        o_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          // Result loads the output register; the same edge frees the accumulator.
          o_acc   <= new_acc;
          o_scale <= new_s;
          o_ovf   <= new_ovf;
          o_valid <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
          acc_s   <= '0;
          ovf_g   <= 1'b0;
        end else begin
          acc   <= new_acc;
          acc_s <= new_s;
          ovf_g <= new_ovf;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mx_dot_accumulator.sv
// tb/tb_mx_dot_accumulator.sv - directed table-driven bench for mx_dot_accumulator
module tb_mx_dot_accumulator;

  logic               i_clk;
  logic               i_rst;
  logic               i_valid0, i_valid1;
  logic               i_ready;
  logic signed [17:0] i_dp;
  logic signed [7:0]  i_scale;
  logic               o_ready0, o_valid0, o_ovf0;
  logic signed [31:0] o_acc0;
  logic signed [7:0]  o_scale0;
  logic               o_ready1, o_valid1, o_ovf1;
  logic signed [17:0] o_acc1;
  logic signed [7:0]  o_scale1;

  int errors = 0;
  int checks = 0;

  mx_dot_accumulator u0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid0), .o_ready(o_ready0),
    .i_dp(i_dp), .i_scale(i_scale), .o_valid(o_valid0), .i_ready(i_ready),
    .o_acc(o_acc0), .o_scale(o_scale0), .o_ovf(o_ovf0)
  );

  mx_dot_accumulator #(.ACC_W(18)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid1), .o_ready(o_ready1),
    .i_dp(i_dp), .i_scale(i_scale), .o_valid(o_valid1), .i_ready(i_ready),
    .o_acc(o_acc1), .o_scale(o_scale1), .o_ovf(o_ovf1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int dp[4];
    int sc[4];
    int exp_acc;
    int exp_scale;
    int exp_ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one beat right after a clock edge and returns #1 after the edge that accepts it.
  task automatic beat(input int dp, input int sc, input bit which);
    int n;
    i_dp    = 18'(dp);
    i_scale = 8'(sc);
    if (which) i_valid1 = 1'b1; else i_valid0 = 1'b1;
    n = 0;
    while (!(which ? o_ready1 : o_ready0)) begin
      @(posedge i_clk); #1;
      n++;
      if (n > 50) begin
        chk("beat_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge i_clk); #1;
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{dp: '{10, 20, -5, 7},     sc: '{3, 3, 3, 3},            exp_acc: 32, exp_scale: 3,   exp_ovf: 0};
    vecs[1] = '{dp: '{8, 3, 0, 0},        sc: '{0, 2, 0, 0},            exp_acc: 5,  exp_scale: 2,   exp_ovf: 0};
    vecs[2] = '{dp: '{5, 7, 0, 0},        sc: '{-100, 100, 100, 100},   exp_acc: 7,  exp_scale: 100, exp_ovf: 0};
    vecs[3] = '{dp: '{-5, 7, 0, 0},       sc: '{-100, 100, 100, 100},   exp_acc: 6,  exp_scale: 100, exp_ovf: 0};
    vecs[4] = '{dp: '{16, -3, -3, 1},     sc: '{0, 1, 0, 1},            exp_acc: 4,  exp_scale: 1,   exp_ovf: 0};
    vecs[5] = '{dp: '{-7, 4, -1, 10},     sc: '{-2, -2, -2, -4},        exp_acc: -2, exp_scale: -2,  exp_ovf: 0};

    i_rst = 1'b1; i_valid0 = 1'b0; i_valid1 = 1'b0; i_ready = 1'b1;
    i_dp = '0; i_scale = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_o_valid", int'(o_valid0), 0);
    chk("reset_o_acc", int'(o_acc0), 0);
    chk("reset_o_scale", int'(o_scale0), 0);
    chk("reset_o_ovf", int'(o_ovf0), 0);
    chk("reset_o_ready", int'(o_ready0), 1);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 3; b++) beat(vecs[v].dp[b], vecs[v].sc[b], 1'b0);
      chk($sformatf("vec%0d_valid_before_last", v), int'(o_valid0), 0);
      beat(vecs[v].dp[3], vecs[v].sc[3], 1'b0);
      chk($sformatf("vec%0d_valid", v), int'(o_valid0), 1);
      chk($sformatf("vec%0d_acc", v), int'(o_acc0), vecs[v].exp_acc);
      chk($sformatf("vec%0d_scale", v), int'(o_scale0), vecs[v].exp_scale);
      chk($sformatf("vec%0d_ovf", v), int'(o_ovf0), vecs[v].exp_ovf);
    end

    // Saturation on the narrow-accumulator instance, then a clean group clears the flag.
    for (int b = 0; b < 4; b++) beat(131071, 0, 1'b1);
    chk("sat_valid", int'(o_valid1), 1);
    chk("sat_acc", int'(o_acc1), 131071);
    chk("sat_ovf", int'(o_ovf1), 1);
    for (int b = 0; b < 4; b++) beat(1, 0, 1'b1);
    chk("post_sat_acc", int'(o_acc1), 4);
    chk("post_sat_ovf", int'(o_ovf1), 0);

    // Backpressure: result held, input stalled with a beat waiting.
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    for (int b = 0; b < 4; b++) beat(1, 0, 1'b0);
    i_dp = 18'sd2; i_scale = 8'sd0; i_valid0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), int'(o_valid0), 1);
      chk($sformatf("bp_acc_c%0d", c), int'(o_acc0), 4);
      chk($sformatf("bp_ready_c%0d", c), int'(o_ready0), 0);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    #1;
    chk("bp_ready_release", int'(o_ready0), 1);
    @(posedge i_clk); #1;
    i_valid0 = 1'b0;
    chk("bp_consumed", int'(o_valid0), 0);
    for (int b = 0; b < 3; b++) beat(2, 0, 1'b0);
    chk("bp_no_loss_valid", int'(o_valid0), 1);
    chk("bp_no_loss_acc", int'(o_acc0), 8);

    // Back-to-back groups with continuous valid.
    @(posedge i_clk); #1;
    i_valid0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_dp = (k < 4) ? 18'sd1 : 18'sd3;
      i_scale = 8'sd0;
      chk($sformatf("b2b_ready_k%0d", k), int'(o_ready0), 1);
      @(posedge i_clk); #1;
      chk($sformatf("b2b_valid_k%0d", k), int'(o_valid0), (k == 3 || k == 7) ? 1 : 0);
      if (k == 3) chk("b2b_acc_a", int'(o_acc0), 4);
      if (k == 7) chk("b2b_acc_b", int'(o_acc0), 12);
    end
    i_valid0 = 1'b0;
    @(posedge i_clk); #1;

    // Reset mid-group discards the partial sum.
    beat(100, 0, 1'b0);
    beat(100, 0, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_valid_during", int'(o_valid0), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_mid_valid_after", int'(o_valid0), 0);
    for (int b = 0; b < 4; b++) beat(1, 0, 1'b0);
    chk("rst_mid_result_valid", int'(o_valid0), 1);
    chk("rst_mid_result_acc", int'(o_acc0), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
